// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter. Accepts one BITLEN-bit word through a valid/ready
// handshake and serialises it LSB-first: start bit, data bits, optional
// parity bit, then STOPBITS stop bits. Each bit is held for
// BITCYCLE = CLK_FREQ/BAUDRATE clocks.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   data_in     word to transmit
//   data_valid  data_in is valid
//   data_ready  block can accept a word (combinational, high in IDLE)
//   tx          serial line, idles high (registered)
//   busy        a frame is in progress (registered)
//   done        one-cycle pulse after the last stop-bit clock (registered)
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int BAUDRATE = 115200,
    parameter int CLK_FREQ = 100_000_000,
    parameter int BITLEN   = 8,
    parameter int PARITY   = 0,
    parameter int STOPBITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITLEN-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BITCYCLE = CLK_FREQ / BAUDRATE;
    localparam int CW       = (BITCYCLE > 1) ? $clog2(BITCYCLE) : 1;
    localparam int IW       = $clog2(BITLEN + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(BITCYCLE - 1);
    localparam logic [IW-1:0] DATA_LAST = IW'(BITLEN - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOPBITS - 1);

    if (BITCYCLE < 2) begin : g_chk_bitcycle
        $error("uart_tx: CLK_FREQ/BAUDRATE must be at least 2");
    end
    if (BITLEN < 5 || BITLEN > 9) begin : g_chk_bitlen
        $error("uart_tx: BITLEN must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOPBITS < 1 || STOPBITS > 2) begin : g_chk_stopbits
        $error("uart_tx: STOPBITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            r_state, w_state;
    logic [CW-1:0]     r_cnt,   w_cnt;
    logic [IW-1:0]     r_idx,   w_idx;
    logic [BITLEN-1:0] r_shift, w_shift;
    logic              r_par,   w_par;
    logic              r_tx,    w_tx;
    logic              r_busy,  w_busy;
    logic              r_done,  w_done;
    logic              w_bit_end;

    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign data_ready = (r_state == ST_IDLE);
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign done       = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // tx/busy/done are computed as next-state values so that they leave the
    // register on the same edge as the state change (tx falls at acceptance).
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_shift = r_shift;
        w_par   = r_par;
        w_tx    = r_tx;
        w_busy  = r_busy;
        w_done  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx   = 1'b1;
                w_busy = 1'b0;
                w_cnt  = '0;
                w_idx  = '0;
                if (data_valid) begin
                    w_shift = data_in;
                    // Even: XOR of data bits; odd: its inverse.
                    w_par   = (PARITY == 1) ? ~(^data_in) : (^data_in);
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                    w_state = ST_START;
                end
            end

            ST_START: begin
                w_cnt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_tx    = r_shift[0];
                    w_state = ST_DATA;
                end
            end

            ST_DATA: begin
                w_cnt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt = '0;
                    if (r_idx == DATA_LAST) begin
                        w_idx = '0;
                        if (PARITY != 0) begin
                            w_tx    = r_par;
                            w_state = ST_PARITY;
                        end else begin
                            w_tx    = 1'b1;
                            w_state = ST_STOP;
                        end
                    end else begin
                        // Bit 0 of the shifted word is the next bit out.
                        w_idx   = r_idx + 1'b1;
                        w_shift = r_shift >> 1;
                        w_tx    = r_shift[1];
                    end
                end
            end

            ST_PARITY: begin
                w_cnt = r_cnt + 1'b1;
                if (w_bit_end) begin
                    w_cnt   = '0;
                    w_tx    = 1'b1;
                    w_state = ST_STOP;
                end
            end

            ST_STOP: begin
                w_cnt = r_cnt + 1'b1;
                w_tx  = 1'b1;
                if (w_bit_end) begin
                    w_cnt = '0;
                    // r_idx counts stop bits here; it is zero on entry.
                    if (r_idx == STOP_LAST) begin
                        w_idx   = '0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_state = ST_IDLE;
                    end else begin
                        w_idx = r_idx + 1'b1;
                    end
                end
            end

            default: begin
                w_state = ST_IDLE;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_cnt   = '0;
                w_idx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. Four instances share clk/rst, all with
// BITCYCLE = 10: inst0 no parity/1 stop, inst1 even parity, inst2 odd parity,
// inst3 no parity/2 stops. Expected line waveforms are built from the frame
// definition (start, data LSB-first, parity, stops) and compared per clock.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int BC = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [4];
    logic [3:0] dv;
    logic [3:0] rdy, txv, bsy, dn;

    int par_mode [4] = '{0, 2, 1, 0};
    int stops    [4] = '{1, 1, 1, 2};

    int tests;
    int fails;

    always #5 clk = ~clk;

    uart_tx #(.BAUDRATE(100_000), .CLK_FREQ(1_000_000), .BITLEN(8), .PARITY(0), .STOPBITS(1)) u0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(rdy[0]), .tx(txv[0]), .busy(bsy[0]), .done(dn[0]));
    uart_tx #(.BAUDRATE(100_000), .CLK_FREQ(1_000_000), .BITLEN(8), .PARITY(2), .STOPBITS(1)) u1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(rdy[1]), .tx(txv[1]), .busy(bsy[1]), .done(dn[1]));
    uart_tx #(.BAUDRATE(100_000), .CLK_FREQ(1_000_000), .BITLEN(8), .PARITY(1), .STOPBITS(1)) u2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .data_valid(dv[2]),
        .data_ready(rdy[2]), .tx(txv[2]), .busy(bsy[2]), .done(dn[2]));
    uart_tx #(.BAUDRATE(100_000), .CLK_FREQ(1_000_000), .BITLEN(8), .PARITY(0), .STOPBITS(2)) u3 (
        .clk(clk), .rst(rst), .data_in(din[3]), .data_valid(dv[3]),
        .data_ready(rdy[3]), .tx(txv[3]), .busy(bsy[3]), .done(dn[3]));

    // Reference frame: list of line levels, one entry per bit period.
    function automatic int frame_bits(input logic [7:0] w, input int pm, input int sb,
                                      output bit fr [16]);
        int n;
        int ones;
        for (int i = 0; i < 16; i++) fr[i] = 1'b1;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1 + i] = w[i];
        n = 9;
        if (pm != 0) begin
            ones = $countones(w);
            // even: make total ones even; odd: make total ones odd
            fr[n] = (pm == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
            n = n + 1;
        end
        for (int s = 0; s < sb; s++) begin
            fr[n] = 1'b1;
            n = n + 1;
        end
        return n;
    endfunction

    // Called at the negedge right after the acceptance edge.
    task automatic check_frame(input int k, input logic [7:0] w, input bit hold,
                               input logic [7:0] next_din, input bit intrude);
        bit         fr [16];
        int         nb, len, e_tx, e_ctl, first_c;
        logic       got_tx, want_tx;
        logic [7:0] dec;
        nb      = frame_bits(w, par_mode[k], stops[k], fr);
        len     = nb * BC;
        e_tx    = 0;
        e_ctl   = 0;
        first_c = -1;
        got_tx  = 1'b0;
        want_tx = 1'b0;
        dec     = 8'h00;
        for (int c = 0; c < len; c++) begin
            if (c == 0) begin
                din[k] = next_din;
                if (!hold) dv[k] = 1'b0;
            end
            if (intrude && c == 30) begin
                dv[k]  = 1'b1;
                din[k] = 8'h3C;
            end
            if (intrude && c == 60) dv[k] = 1'b0;
            if (txv[k] !== fr[c / BC]) begin
                if (first_c < 0) begin
                    first_c = c;
                    got_tx  = txv[k];
                    want_tx = fr[c / BC];
                end
                e_tx++;
            end
            if (bsy[k] !== 1'b1 || dn[k] !== 1'b0 || rdy[k] !== 1'b0) e_ctl++;
            if (c >= BC && c < 9 * BC && (c % BC) == BC / 2) dec[c / BC - 1] = txv[k];
            @(negedge clk);
        end
        tests++;
        if (e_tx != 0) begin
            fails++;
            $display("FAIL frame_tx inst%0d word %h: %0d bad samples, first at clk %0d got %b want %b",
                     k, w, e_tx, first_c, got_tx, want_tx);
        end
        tests++;
        if (dec !== w) begin
            fails++;
            $display("FAIL decode inst%0d: got %h want %h", k, dec, w);
        end
        tests++;
        if (e_ctl != 0) begin
            fails++;
            $display("FAIL frame_ctl inst%0d word %h: %0d clocks not busy=1 done=0 ready=0",
                     k, w, e_ctl);
        end
        tests++;
        if ({dn[k], bsy[k], txv[k], rdy[k]} !== 4'b1011) begin
            fails++;
            $display("FAIL frame_end inst%0d at clk %0d: done,busy,tx,ready got %b want 1011",
                     k, len, {dn[k], bsy[k], txv[k], rdy[k]});
        end
        if (!hold) begin
            @(negedge clk);
            tests++;
            if ({dn[k], bsy[k], txv[k]} !== 3'b001) begin
                fails++;
                $display("FAIL post_frame inst%0d: done,busy,tx got %b want 001",
                         k, {dn[k], bsy[k], txv[k]});
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] w, input bit hold,
                        input logic [7:0] next_din, input bit intrude);
        int waited;
        waited = 0;
        @(negedge clk);
        din[k] = w;
        dv[k]  = 1'b1;
        while (rdy[k] !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (rdy[k] !== 1'b1) begin
            fails++;
            $display("FAIL accept_timeout inst%0d: ready got %b want 1", k, rdy[k]);
            dv[k] = 1'b0;
            return;
        end
        @(negedge clk);
        check_frame(k, w, hold, next_din, intrude);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (txv !== 4'hF) begin fails++; $display("FAIL reset_tx got %b want 1111", txv); end
        tests++;
        if (bsy !== 4'h0) begin fails++; $display("FAIL reset_busy got %b want 0000", bsy); end
        tests++;
        if (dn !== 4'h0) begin fails++; $display("FAIL reset_done got %b want 0000", dn); end
        tests++;
        if (rdy !== 4'hF) begin fails++; $display("FAIL reset_ready got %b want 1111", rdy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send(0, 8'hA5, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) send(0, 8'($urandom), 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_parity();
        for (int k = 1; k <= 2; k++) begin
            send(k, 8'hA5, 1'b0, 8'h00, 1'b0);
            for (int i = 0; i < 8; i++) send(k, 8'($urandom), 1'b0, 8'h00, 1'b0);
        end
    endtask

    task automatic test_stop2_back_to_back();
        // 0x00 with 0xFF held valid (data_in changes right after acceptance)
        send(3, 8'h00, 1'b1, 8'hFF, 1'b0);
        @(negedge clk);
        check_frame(3, 8'hFF, 1'b0, 8'hFF, 1'b0);
    endtask

    task automatic test_busy_ignore();
        send(0, 8'($urandom), 1'b0, 8'h00, 1'b1);
        repeat (5) @(negedge clk);
        tests++;
        if (bsy[0] !== 1'b0 || txv[0] !== 1'b1) begin
            fails++;
            $display("FAIL busy_ignore: busy,tx got %b%b want 01", bsy[0], txv[0]);
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        int done_seen;
        waited = 0;
        @(negedge clk);
        din[0] = 8'($urandom);
        dv[0]  = 1'b1;
        while (rdy[0] !== 1'b1 && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        dv[0] = 1'b0;
        repeat (44) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({txv[0], bsy[0], dn[0], rdy[0]} !== 4'b1001) begin
            fails++;
            $display("FAIL reset_mid: tx,busy,done,ready got %b want 1001",
                     {txv[0], bsy[0], dn[0], rdy[0]});
        end
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dn[0] !== 1'b0 || txv[0] !== 1'b1) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++;
            $display("FAIL reset_mid_quiet: %0d clocks with done/tx activity, want 0", done_seen);
        end
        send(0, 8'h5A, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [256];
        for (int i = 0; i < 256; i++) words[i] = 8'($urandom);
        send(0, words[0], 1'b1, words[1], 1'b0);
        for (int i = 1; i < 256; i++) begin
            @(negedge clk);
            if (i < 255) check_frame(0, words[i], 1'b1, words[i + 1], 1'b0);
            else         check_frame(0, words[i], 1'b0, 8'h00, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b1;
        dv    = 4'h0;
        for (int k = 0; k < 4; k++) din[k] = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_stop2_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
